mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single-port synchronous word RAM (1-cycle read latency, byte-lane write enables, word-indexed address) between the instruction-fetch port and the load/store data port.
- Round-robin arbitration; converts byte addresses to word indices; generates byte-lane masks and replicated store data; extracts and sign/zero-extends load data.
- Flags misaligned and out-of-range accesses.
- Sits between the core pipeline and the RAM instance.

Parameters:
- NUM_WORDS, 32, number of 32-bit words in the attached RAM; valid word index is 0..NUM_WORDS-1.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_req  in  1  instruction read request, held until i_gnt
- i_addr  in  32  instruction byte address
- i_gnt  out  1  instruction request accepted this cycle
- i_rvalid  out  1  i_rdata valid (cycle after i_gnt)
- i_rdata  out  32  fetched word
- i_err  out  1  fetch fault (cycle after i_gnt)
- d_req  in  1  data request, held until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- d_unsigned  in  1  zero-extend load
- d_addr  in  32  data byte address
- d_wdata  in  32  store data, right-aligned
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  d_rdata valid (cycle after load grant)
- d_rdata  out  32  extended load result
- d_err  out  1  data fault (cycle after d_gnt)
- ram_read_enable  out  1  to RAM read_enable
- ram_write_enable  out  4  to RAM write_enable
- ram_address  out  32  word index, byte address >> 2
- ram_data_in  out  32  to RAM data_in
- ram_data_out  in  32  from RAM data_out

Behaviour:
- Reset values: i_rvalid, i_err, d_rvalid, d_err = 0; last_grant = DATA (instruction port wins the first conflict); pending-read registers cleared. Reset mid-access drops the pending response; no rvalid/err follows.
- Arbitration (combinational, every cycle, no idle state):
  - One requester only: it is granted.
  - Both: the port not granted last wins.
  - last_grant updates on every grant.
  - One gnt per cycle max.
  - Back-to-back grants allowed; a grant may coincide with the previous access's rvalid.
- Grant cycle: RAM command is driven combinationally from the winner's inputs. Ungranted cycles: ram_read_enable = 0, ram_write_enable = 0, ram_address = 0, ram_data_in = 0.
- Fault checks, evaluated at grant:
  - Instruction: addr[1:0] != 0.
  - Data: size 11; half with addr[0] = 1; word with addr[1:0] != 0.
  - Either port: addr[31:2] >= NUM_WORDS.
  - A faulting access is still granted, but with no RAM enables. Next cycle err = 1 and rvalid = 0.
- Instruction read: ram_read_enable = 1, ram_address = i_addr >> 2. Next cycle i_rvalid = 1, i_rdata = ram_data_out.
- Load: ram_read_enable = 1. Register offset = addr[1:0], size, unsigned. Next cycle d_rvalid = 1 and d_rdata is taken from ram_data_out:
  - Byte: bits [8*off+7 : 8*off].
  - Half: bits [16*off[1]+15 : 16*off[1]].
  - Sign- or zero-extended to 32 bits.
- Store:
  - Byte: mask 0001 << off; ram_data_in = wdata[7:0] replicated x4.
  - Half: mask 0011 << off; ram_data_in = wdata[15:0] replicated x2.
  - Word: mask 1111; ram_data_in = wdata.
  - Store completes at grant; no rvalid. d_err is the only possible response.
- rdata outputs are don't-care when rvalid = 0; the bench must not check them.
- The cycle after a grant, the ungranted port's rvalid and err are 0.

Decomposition:
- Shared package (mem_pkg): SIZE_BYTE/HALF/WORD encodings, GRANT_INSTR/GRANT_DATA constants.
- Sub-module load_align (combinational): ram word + offset + size + unsigned -> extended result.
- Lane-mask and replication logic stay inline.

Test Plan:
- Reset then i_req, i_addr = 0x8 -> i_gnt that cycle; ram_address = 2, ram_read_enable = 1; next cycle i_rvalid = 1, i_rdata = mem[2].
- Store byte d_addr = 0x13, d_wdata = 0xAB -> ram_address = 4, ram_write_enable = 1000, ram_data_in = 0xABABABAB. Then signed load byte 0x13 -> d_rdata = 0xFFFFFFAB; unsigned -> 0x000000AB.
- i_req and d_req held high 4 cycles from reset -> grants alternate I, D, I, D; each gets its correct rvalid the following cycle.
- Load half d_addr = 0x6 with mem[1] = 0x8001_7FFF -> d_rdata = 0xFFFF8001. Then d_addr = 0x5 size half -> d_err next cycle; no RAM enables; d_rvalid = 0.
- d_addr = 4*NUM_WORDS word store -> d_gnt = 1, ram_write_enable = 0, d_err = 1 next cycle. i_addr = 0x2 -> i_err.
- Assert rst_n = 0 in the cycle after a load grant -> d_rvalid stays 0; after release, first conflict grants the instruction port.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the memory arbiter slice.
//   size_e   : load/store access size encoding carried on d_size
//   grant_e  : identifies which port won the most recent grant
//   out_of_range : true when a word index lies beyond the attached RAM
package mem_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } size_e;

  typedef enum logic {
    GRANT_INSTR = 1'b0,
    GRANT_DATA  = 1'b1
  } grant_e;

  function automatic logic out_of_range(input logic [29:0] word_idx,
                                        input int unsigned num_words);
    return 32'(word_idx) >= num_words;
  endfunction

endpackage

// File: rtl/load_align.sv
// Load data alignment: picks the addressed byte or halfword out of the RAM
// word and sign- or zero-extends it to 32 bits. Word loads pass through.
//   word        : raw RAM read data
//   offset      : byte offset of the access within the word
//   size        : access size of the load
//   is_unsigned : zero-extend instead of sign-extend
//   result      : extended load value
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  size_e       size,
  input  logic        is_unsigned,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        sign_bit;

  always_comb begin
    byte_sel = word[{offset, 3'b000} +: 8];
    // Halfwords are always 2-byte aligned, so offset[1] picks the half.
    half_sel = offset[1] ? word[31:16] : word[15:0];
    sign_bit = 1'b0;
    result   = word;
    case (size)
      SIZE_BYTE: begin
        sign_bit = ~is_unsigned & byte_sel[7];
        result   = {{24{sign_bit}}, byte_sel};
      end
      SIZE_HALF: begin
        sign_bit = ~is_unsigned & half_sel[15];
        result   = {{16{sign_bit}}, half_sel};
      end
      default: result = word;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous word RAM between
// the instruction-fetch port and the load/store data port.
//   i_*   : instruction fetch request / grant / one-cycle-later response
//   d_*   : load/store request / grant / one-cycle-later response
//   ram_* : command to, and read data from, the RAM (word-indexed address)
// Misaligned or out-of-range accesses are granted without touching the RAM
// and answered with an err pulse the following cycle.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned NUM_WORDS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  output logic        i_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [1:0]  d_size,
  input  logic        d_unsigned,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        ram_read_enable,
  output logic [3:0]  ram_write_enable,
  output logic [31:0] ram_address,
  output logic [31:0] ram_data_in,
  input  logic [31:0] ram_data_out
);

  size_e  req_size;
  logic   grant_i, grant_d, fault_i, fault_d, access_i, access_d;

  grant_e last_grant_q, last_grant_d;
  logic   i_rvalid_q, i_rvalid_d, i_err_q, i_err_d;
  logic   d_rvalid_q, d_rvalid_d, d_err_q, d_err_d;
  logic [1:0] d_off_q, d_off_d;
  size_e  d_size_q, d_size_d;
  logic   d_unsigned_q, d_unsigned_d;

  assign req_size = size_e'(d_size);

  // Arbitration and fault detection for the current cycle's requests.
  always_comb begin
    // On a conflict the port that did not win last time goes first.
    grant_i = i_req & (~d_req | (last_grant_q == GRANT_DATA));
    grant_d = d_req & ~grant_i;

    fault_i = (i_addr[1:0] != 2'b00) | out_of_range(i_addr[31:2], NUM_WORDS);

    fault_d = out_of_range(d_addr[31:2], NUM_WORDS);
    case (req_size)
      SIZE_HALF: fault_d = fault_d | d_addr[0];
      SIZE_WORD: fault_d = fault_d | (d_addr[1:0] != 2'b00);
      SIZE_RSVD: fault_d = 1'b1;
      default:   fault_d = fault_d;
    endcase

    access_i = grant_i & ~fault_i;
    access_d = grant_d & ~fault_d;
  end

  // RAM command: idle (all zero) unless a non-faulting access is granted.
  always_comb begin
    // NOTE: every output gets a default before any branch, so no path
    // leaves a value unassigned and no latch is inferred.
    ram_read_enable  = 1'b0;
    ram_write_enable = 4'b0000;
    ram_address      = '0;
    ram_data_in      = '0;
    if (access_i) begin
      ram_read_enable = 1'b1;
      ram_address     = {2'b00, i_addr[31:2]};
    end else if (access_d) begin
      ram_address = {2'b00, d_addr[31:2]};
      if (d_we) begin
        // Store data is replicated across lanes so the mask alone selects
        // which bytes of the word actually change.
        case (req_size)
          SIZE_BYTE: begin
            ram_write_enable = 4'b0001 << d_addr[1:0];
            ram_data_in      = {4{d_wdata[7:0]}};
          end
          SIZE_HALF: begin
            ram_write_enable = 4'b0011 << d_addr[1:0];
            ram_data_in      = {2{d_wdata[15:0]}};
          end
          default: begin
            ram_write_enable = 4'b1111;
            ram_data_in      = d_wdata;
          end
        endcase
      end else begin
        ram_read_enable = 1'b1;
      end
    end
  end

  // Next-state: response flags for the following cycle and load context.
  always_comb begin
    last_grant_d = last_grant_q;
    if (grant_i)      last_grant_d = GRANT_INSTR;
    else if (grant_d) last_grant_d = GRANT_DATA;

    i_rvalid_d = access_i;
    i_err_d    = grant_i & fault_i;
    d_rvalid_d = access_d & ~d_we;
    d_err_d    = grant_d & fault_d;

    d_off_d      = d_off_q;
    d_size_d     = d_size_q;
    d_unsigned_d = d_unsigned_q;
    if (access_d && !d_we) begin
      d_off_d      = d_addr[1:0];
      d_size_d     = req_size;
      d_unsigned_d = d_unsigned;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: state updates use non-blocking assignments so every flop
      // samples the pre-edge value, independent of statement order.
      last_grant_q <= GRANT_DATA;
      i_rvalid_q   <= 1'b0;
      i_err_q      <= 1'b0;
      d_rvalid_q   <= 1'b0;
      d_err_q      <= 1'b0;
      d_off_q      <= 2'b00;
      d_size_q     <= SIZE_BYTE;
      d_unsigned_q <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      i_rvalid_q   <= i_rvalid_d;
      i_err_q      <= i_err_d;
      d_rvalid_q   <= d_rvalid_d;
      d_err_q      <= d_err_d;
      d_off_q      <= d_off_d;
      d_size_q     <= d_size_d;
      d_unsigned_q <= d_unsigned_d;
    end
  end

  load_align u_load_align (
    .word        (ram_data_out),
    .offset      (d_off_q),
    .size        (d_size_q),
    .is_unsigned (d_unsigned_q),
    .result      (d_rdata)
  );

  assign i_gnt    = grant_i;
  assign d_gnt    = grant_d;
  assign i_rvalid = i_rvalid_q;
  assign i_err    = i_err_q;
  assign i_rdata  = ram_data_out;
  assign d_rvalid = d_rvalid_q;
  assign d_err    = d_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a behavioural RAM, a byte-array
// reference model of the memory system, a directed vector table, a few
// hand-written multi-cycle sequences and randomized traffic.
module tb_mem_arbiter;

  localparam int NW = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, i_gnt, i_rvalid, i_err;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_unsigned, d_gnt, d_rvalid, d_err;
  logic [1:0]  d_size;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        ram_read_enable;
  logic [3:0]  ram_write_enable;
  logic [31:0] ram_address, ram_data_in, ram_data_out;

  always #5 clk = ~clk;

  mem_arbiter #(.NUM_WORDS(NW)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_req            (i_req),
    .i_addr           (i_addr),
    .i_gnt            (i_gnt),
    .i_rvalid         (i_rvalid),
    .i_rdata          (i_rdata),
    .i_err            (i_err),
    .d_req            (d_req),
    .d_we             (d_we),
    .d_size           (d_size),
    .d_unsigned       (d_unsigned),
    .d_addr           (d_addr),
    .d_wdata          (d_wdata),
    .d_gnt            (d_gnt),
    .d_rvalid         (d_rvalid),
    .d_rdata          (d_rdata),
    .d_err            (d_err),
    .ram_read_enable  (ram_read_enable),
    .ram_write_enable (ram_write_enable),
    .ram_address      (ram_address),
    .ram_data_in      (ram_data_in),
    .ram_data_out     (ram_data_out)
  );

  // Synchronous single-port RAM with byte-lane write enables.
  logic [31:0] ram_mem [NW];
  logic [31:0] ram_q = '0;
  assign ram_data_out = ram_q;

  always @(posedge clk) begin
    if (ram_address < 32'(NW)) begin
      if (ram_read_enable) ram_q <= ram_mem[ram_address[4:0]];
      for (int b = 0; b < 4; b++)
        if (ram_write_enable[b])
          ram_mem[ram_address[4:0]][8*b +: 8] <= ram_data_in[8*b +: 8];
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  ref_bytes [4*NW];
  bit          m_last_data;          // 1 when the data port won last
  bit          e_irv, e_ierr, e_drv, e_derr;
  logic [31:0] e_irdata, e_drdata;
  bit          last_gi, last_gd;

  function automatic bit ref_i_fault(input logic [31:0] a);
    return (a % 4 != 0) || ((a / 4) >= 32'(NW));
  endfunction

  function automatic bit ref_d_fault(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd3) return 1'b1;
    if ((a / 4) >= 32'(NW)) return 1'b1;
    if (sz == 2'd1 && (a % 2 != 0)) return 1'b1;
    if (sz == 2'd2 && (a % 4 != 0)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz,
                                           input logic uns);
    int nb;
    logic [31:0] v;
    nb = 1 << sz;
    v  = '0;
    for (int b = 0; b < nb; b++) v = v | (32'(ref_bytes[int'(a) + b]) << (8*b));
    if (nb < 4 && !uns && v[8*nb-1]) v = v | ~((32'h1 << (8*nb)) - 32'h1);
    return v;
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
    int nb;
    nb = 1 << sz;
    for (int b = 0; b < nb; b++) ref_bytes[int'(a) + b] = wd[8*b +: 8];
  endtask

  task automatic check_resp();
    check("i_rvalid", 32'(i_rvalid), 32'(e_irv));
    check("i_err",    32'(i_err),    32'(e_ierr));
    check("d_rvalid", 32'(d_rvalid), 32'(e_drv));
    check("d_err",    32'(d_err),    32'(e_derr));
    if (e_irv) check("i_rdata", i_rdata, e_irdata);
    if (e_drv) check("d_rdata", d_rdata, e_drdata);
  endtask

  // One clock cycle: check last cycle's responses, drive new requests,
  // check grants/RAM enables and predict the next responses.
  task automatic step(input logic ir, input logic [31:0] ia, input logic dr,
                      input logic we, input logic [1:0] sz, input logic uns,
                      input logic [31:0] da, input logic [31:0] wd);
    bit gi, gd, fi, fd;
    @(negedge clk);
    check_resp();
    i_req = ir; i_addr = ia;
    d_req = dr; d_we = we; d_size = sz; d_unsigned = uns; d_addr = da; d_wdata = wd;
    #1;
    gi = ir && (!dr || m_last_data);
    gd = dr && !gi;
    fi = ref_i_fault(ia);
    fd = ref_d_fault(sz, da);
    check("i_gnt", 32'(i_gnt), 32'(gi));
    check("d_gnt", 32'(d_gnt), 32'(gd));
    check("ram_re", 32'(ram_read_enable), 32'((gi && !fi) || (gd && !fd && !we)));
    check("ram_we_any", 32'(|ram_write_enable), 32'(gd && !fd && we));
    e_irv    = gi && !fi;
    e_ierr   = gi && fi;
    e_irdata = e_irv ? ref_load(ia, 2'd2, 1'b1) : '0;
    e_drv    = gd && !fd && !we;
    e_derr   = gd && fd;
    e_drdata = e_drv ? ref_load(da, sz, uns) : '0;
    if (gd && !fd && we) ref_store(da, sz, wd);
    if (gi) m_last_data = 1'b0;
    else if (gd) m_last_data = 1'b1;
    last_gi = gi;
    last_gd = gd;
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, 1'b0, 2'd0, 1'b0, '0, '0);
  endtask

  // Asserts reset immediately (possibly mid-cycle), holds two cycles.
  task automatic do_reset();
    rst_n = 1'b0;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_size = 2'd0; d_unsigned = 1'b0; d_addr = '0; d_wdata = '0;
    m_last_data = 1'b1;
    e_irv = 1'b0; e_ierr = 1'b0; e_drv = 1'b0; e_derr = 1'b0;
    #1;
    check("rst_i_rvalid", 32'(i_rvalid), 32'h0);
    check("rst_d_rvalid", 32'(d_rvalid), 32'h0);
    check("rst_i_err",    32'(i_err),    32'h0);
    check("rst_d_err",    32'(d_err),    32'h0);
    check("rst_ram_re",   32'(ram_read_enable), 32'h0);
    repeat (2) begin
      @(negedge clk);
      check("rst_hold_d_rvalid", 32'(d_rvalid), 32'h0);
      check("rst_hold_i_rvalid", 32'(i_rvalid), 32'h0);
    end
    rst_n = 1'b1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        ir;
    logic [31:0] ia;
    logic        dr;
    logic        we;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] da;
    logic [31:0] wd;
    logic        e_re;
    logic [3:0]  e_we;
    logic [31:0] e_addr;
    logic [31:0] e_din;
    logic        has_rd;
    logic [31:0] e_rd;
  } vec_t;

  function automatic vec_t mk(input logic ir, input logic [31:0] ia, input logic dr,
                              input logic we, input logic [1:0] sz, input logic uns,
                              input logic [31:0] da, input logic [31:0] wd,
                              input logic e_re, input logic [3:0] e_we,
                              input logic [31:0] e_addr, input logic [31:0] e_din,
                              input logic has_rd, input logic [31:0] e_rd);
    vec_t v;
    v.ir = ir; v.ia = ia; v.dr = dr; v.we = we; v.sz = sz; v.uns = uns;
    v.da = da; v.wd = wd; v.e_re = e_re; v.e_we = e_we; v.e_addr = e_addr;
    v.e_din = e_din; v.has_rd = has_rd; v.e_rd = e_rd;
    return v;
  endfunction

  vec_t vecs [17];

  logic        ip, dp, rwe, runs;
  logic [1:0]  rsz;
  logic [31:0] ria, rda, rwd;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //          ir  ia        dr  we  sz    uns da        wd            re  we       addr   din          rd  expected rdata
    vecs[0]  = mk(1, 32'h08, 0, 0, 2'd0, 0, 32'h00, 32'h0,        1, 4'b0000, 32'h02, 32'h0,        0, 32'h0);
    vecs[1]  = mk(0, 32'h00, 1, 1, 2'd0, 0, 32'h13, 32'hAB,       0, 4'b1000, 32'h04, 32'hABABABAB, 0, 32'h0);
    vecs[2]  = mk(0, 32'h00, 1, 0, 2'd0, 0, 32'h13, 32'h0,        1, 4'b0000, 32'h04, 32'h0,        1, 32'hFFFFFFAB);
    vecs[3]  = mk(0, 32'h00, 1, 0, 2'd0, 1, 32'h13, 32'h0,        1, 4'b0000, 32'h04, 32'h0,        1, 32'h000000AB);
    vecs[4]  = mk(0, 32'h00, 1, 1, 2'd2, 0, 32'h04, 32'h80017FFF, 0, 4'b1111, 32'h01, 32'h80017FFF, 0, 32'h0);
    vecs[5]  = mk(0, 32'h00, 1, 0, 2'd1, 0, 32'h06, 32'h0,        1, 4'b0000, 32'h01, 32'h0,        1, 32'hFFFF8001);
    vecs[6]  = mk(0, 32'h00, 1, 0, 2'd1, 0, 32'h05, 32'h0,        0, 4'b0000, 32'h00, 32'h0,        0, 32'h0);
    vecs[7]  = mk(0, 32'h00, 1, 1, 2'd2, 0, 32'h80, 32'h12345678, 0, 4'b0000, 32'h00, 32'h0,        0, 32'h0);
    vecs[8]  = mk(1, 32'h02, 0, 0, 2'd0, 0, 32'h00, 32'h0,        0, 4'b0000, 32'h00, 32'h0,        0, 32'h0);
    vecs[9]  = mk(0, 32'h00, 1, 1, 2'd1, 0, 32'h2A, 32'h1234CDEF, 0, 4'b1100, 32'h0A, 32'hCDEFCDEF, 0, 32'h0);
    vecs[10] = mk(0, 32'h00, 1, 0, 2'd1, 1, 32'h2A, 32'h0,        1, 4'b0000, 32'h0A, 32'h0,        1, 32'h0000CDEF);
    vecs[11] = mk(0, 32'h00, 1, 0, 2'd3, 0, 32'h00, 32'h0,        0, 4'b0000, 32'h00, 32'h0,        0, 32'h0);
    vecs[12] = mk(0, 32'h00, 1, 1, 2'd0, 0, 32'h7D, 32'h55,       0, 4'b0010, 32'h1F, 32'h55555555, 0, 32'h0);
    vecs[13] = mk(0, 32'h00, 1, 0, 2'd0, 1, 32'h7D, 32'h0,        1, 4'b0000, 32'h1F, 32'h0,        1, 32'h00000055);
    vecs[14] = mk(1, 32'h7C, 0, 0, 2'd0, 0, 32'h00, 32'h0,        1, 4'b0000, 32'h1F, 32'h0,        0, 32'h0);
    vecs[15] = mk(1, 32'h80, 0, 0, 2'd0, 0, 32'h00, 32'h0,        0, 4'b0000, 32'h00, 32'h0,        0, 32'h0);
    vecs[16] = mk(0, 32'h00, 1, 0, 2'd2, 0, 32'h7C, 32'h0,        1, 4'b0000, 32'h1F, 32'h0,        0, 32'h0);

    do_reset();

    // Preload every word through the data port with random contents.
    for (int w = 0; w < NW; w++)
      step(1'b0, '0, 1'b1, 1'b1, 2'd2, 1'b0, 32'(w * 4), $urandom());

    for (int i = 0; i < 17; i++) begin
      step(vecs[i].ir, vecs[i].ia, vecs[i].dr, vecs[i].we, vecs[i].sz, vecs[i].uns,
           vecs[i].da, vecs[i].wd);
      check($sformatf("vec%0d_re", i),   32'(ram_read_enable),  32'(vecs[i].e_re));
      check($sformatf("vec%0d_we", i),   32'(ram_write_enable), 32'(vecs[i].e_we));
      check($sformatf("vec%0d_addr", i), ram_address,           vecs[i].e_addr);
      check($sformatf("vec%0d_din", i),  ram_data_in,           vecs[i].e_din);
      if (vecs[i].has_rd) begin
        @(posedge clk);
        #1;
        check($sformatf("vec%0d_rdata", i), d_rdata, vecs[i].e_rd);
      end
    end
    idle();

    // Both ports requesting from reset: grants alternate I, D, I, D.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 32'h8, 1'b1, 1'b0, 2'd2, 1'b0, 32'h4, '0);
      check($sformatf("alt%0d_i_gnt", k), 32'(i_gnt), 32'((k % 2) == 0));
      check($sformatf("alt%0d_d_gnt", k), 32'(d_gnt), 32'((k % 2) == 1));
    end
    idle();

    // Reset asserted before the edge that would deliver a load response.
    step(1'b0, '0, 1'b1, 1'b0, 2'd2, 1'b0, 32'h4, '0);
    check("midrst_d_gnt", 32'(d_gnt), 32'h1);
    #2;
    do_reset();
    step(1'b1, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0, 32'h4, '0);
    check("post_reset_conflict_i_gnt", 32'(i_gnt), 32'h1);
    check("post_reset_conflict_d_gnt", 32'(d_gnt), 32'h0);
    idle();

    // Randomized traffic; each request is held until granted.
    ip = 1'b0; dp = 1'b0;
    ria = '0; rda = '0; rwd = '0; rwe = 1'b0; rsz = 2'd0; runs = 1'b0;
    for (int n = 0; n < 800; n++) begin
      if (!ip && $urandom_range(0, 2) != 0) begin
        ip = 1'b1;
        if ($urandom_range(0, 9) == 0) ria = 32'($urandom_range(0, 4*NW + 16));
        else ria = 32'($urandom_range(0, NW - 1)) << 2;
      end
      if (!dp && $urandom_range(0, 2) != 0) begin
        dp   = 1'b1;
        rwe  = 1'($urandom_range(0, 1));
        runs = 1'($urandom_range(0, 1));
        rsz  = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
        rwd  = $urandom();
        rda  = 32'($urandom_range(0, 4*NW + 8));
        if ($urandom_range(0, 3) != 0) begin
          if (rsz == 2'd1) rda = rda & ~32'h1;
          if (rsz == 2'd2) rda = rda & ~32'h3;
        end
      end
      step(ip, ria, dp, rwe, rsz, runs, rda, rwd);
      if (last_gi) ip = 1'b0;
      if (last_gd) dp = 1'b0;
    end
    idle();
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
